// File: rtl/sawwave_generator.sv
// sawwave_generator: PWM sawtooth source; a free-running frame counter is compared
//   against a ramp level that steps once per frame, so the filtered Pulse is a sawtooth.
// Latency: Pulse is registered one clock behind the compare; the enable switch takes two
//   synchroniser flops before the counter starts. Backpressure: none, the output is free-running.
// Ports:
//   sysclk      - system clock, rising edge only
//   Reset_n     - synchronous active-low reset, overrides enable
//   Enable_SW_1 - asynchronous front-panel enable (1 = run, 0 = hold cleared)
//   Pulse       - registered PWM output
//   Saw_Level   - current ramp level (observability)
module sawwave_generator #(
  parameter int PWM_BITS = 8,
  parameter int SAW_STEP = 8
) (
  input  logic                sysclk,
  input  logic                Reset_n,
  input  logic                Enable_SW_1,
  output logic                Pulse,
  output logic [PWM_BITS-1:0] Saw_Level
);

  // Step truncated to the ramp width; the addition wraps modulo 2^PWM_BITS.
  localparam logic [PWM_BITS-1:0] STEP = PWM_BITS'(SAW_STEP);

  logic                r_en_s1;
  logic                r_en_s2;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic                w_frame_end;

  assign w_frame_end = (r_pwm_cnt == {PWM_BITS{1'b1}});

  // Two-flop synchroniser for the asynchronous switch.
  always_ff @(posedge sysclk) begin
    if (!Reset_n) begin
      r_en_s1 <= 1'b0;
      r_en_s2 <= 1'b0;
    end else begin
      r_en_s1 <= Enable_SW_1;
      r_en_s2 <= r_en_s1;
    end
  end

  // Frame counter, ramp level and PWM compare. Disabling discards any partial
  // frame, so the ramp always restarts from level 0.
  always_ff @(posedge sysclk) begin
    if (!Reset_n || !r_en_s2) begin
      r_pwm_cnt <= '0;
      Saw_Level <= '0;
      Pulse     <= 1'b0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      if (w_frame_end) begin
        Saw_Level <= Saw_Level + STEP;
      end
      // Pre-edge values: level L gives L high clocks per frame, never 100 %.
      Pulse <= (r_pwm_cnt < Saw_Level);
    end
  end

endmodule

// File: tb/tb_sawwave_generator.sv
module tb_sawwave_generator;

  logic       sysclk;
  logic       Reset_n;
  logic       Enable_SW_1;
  logic       Pulse;
  logic [7:0] Saw_Level;

  sawwave_generator #(.PWM_BITS(8), .SAW_STEP(8)) dut (
    .sysclk      (sysclk),
    .Reset_n     (Reset_n),
    .Enable_SW_1 (Enable_SW_1),
    .Pulse       (Pulse),
    .Saw_Level   (Saw_Level)
  );

  initial sysclk = 1'b0;
  always #10 sysclk = ~sysclk;

  typedef struct packed {
    logic       pulse;
    logic [7:0] level;
    logic       first;
    logic       last;
    int         hi;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Reference state: enable pipeline as described for the switch, plus the number of
  // counting edges since the last clear. Expected outputs are derived arithmetically:
  // counting edge j shows level 8*((j+1)/256 mod 32) and Pulse = (j mod 256) < 8*frame.
  logic m_s1 = 1'b0;
  logic m_s2 = 1'b0;
  int   t    = 0;

  task automatic step(input logic r, input logic e);
    exp_t x;
    int   j;
    Reset_n     = r;
    Enable_SW_1 = e;
    @(posedge sysclk);
    #1;
    cyc++;
    x = '0;
    if (!r) begin
      m_s1 = 1'b0;
      m_s2 = 1'b0;
      t    = 0;
    end else begin
      if (m_s2) begin
        j       = t;
        x.pulse = ((j % 256) < 8 * ((j / 256) % 32));
        x.level = 8'(8 * (((j + 1) / 256) % 32));
        x.first = ((j % 256) == 0);
        x.last  = ((j % 256) == 255);
        x.hi    = 8 * ((j / 256) % 32);
        t++;
      end else begin
        t = 0;
      end
      m_s2 = m_s1;
      m_s1 = e;
    end
    q.push_back(x);
  endtask

  // Monitor: every clock the DUT presents Pulse/Saw_Level; compare against the
  // queued expectation and tally high time per complete frame.
  initial begin
    exp_t e;
    int   acc;
    acc = 0;
    forever begin
      @(negedge sysclk);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_checks++;
        if (Pulse !== e.pulse) begin
          n_fail++;
          $display("FAIL pulse cyc=%0d got=%b exp=%b", cyc, Pulse, e.pulse);
        end
        n_checks++;
        if (Saw_Level !== e.level) begin
          n_fail++;
          $display("FAIL level cyc=%0d got=%0d exp=%0d", cyc, Saw_Level, e.level);
        end
        if (e.first) acc = 0;
        if (Pulse === 1'b1) acc++;
        if (e.last) begin
          n_checks++;
          if (acc != e.hi) begin
            n_fail++;
            $display("FAIL frame_high cyc=%0d got=%0d exp=%0d", cyc, acc, e.hi);
          end
        end
      end
    end
  end

  initial begin
    Reset_n     = 1'b0;
    Enable_SW_1 = 1'b1;

    // Reset held 5 clocks with the switch high.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);

    // Ramp through all 32 levels, the wrap to 0 and into the next period.
    for (int i = 0; i < 2 + 33 * 256 + 10; i++) step(1'b1, 1'b1);

    // 20 us more, then disable mid-frame for 80 us.
    for (int i = 0; i < 1000; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 4000; i++) step(1'b1, 1'b0);

    // Re-enable: ramp restarts from level 0.
    for (int i = 0; i < 2 + 3 * 256 + 5; i++) step(1'b1, 1'b1);

    // Run into the level-128 frame, then a single-clock reset.
    while (t < 16 * 256 + 50) step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    for (int i = 0; i < 2 + 2 * 256 + 5; i++) step(1'b1, 1'b1);

    @(negedge sysclk);
    #1;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got=%0d pending exp=0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
